// File: rtl/time_pulse_gen.sv
// time_pulse_gen: time-pulse and memory-strobe generator.
// A 2-bit phase counter (PH) and a 1..12 time counter (TC) give 48 clocks
// per memory cycle. T01..T12 are active-low one-hot pulses, four clocks each;
// the RT/WT/TT/CT strobes and MCT are decoded from PH and TC.
// Optional feature: define TPG_MONITOR_STOP_EN to enable monitor stop/step
// (MSTP/MSTRT and the HOLD mode). Without it HOLD is unreachable and
// STOPPED is always 0.
module time_pulse_gen (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        GOJAM,
  input  logic        MSTP,
  input  logic        MSTRT,
  output logic [11:0] T_n,
  output logic        T10_n,
  output logic        RT_n,
  output logic        WT_n,
  output logic        TT_n,
  output logic        CT_n,
  output logic        MCT,
  output logic        STOPPED
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } mode_t;

  mode_t       mode, mode_nx;
  logic [1:0]  ph, ph_nx;
  logic [3:0]  tc, tc_nx;

  logic [11:0] t_nx;
  logic        rt_nx, wt_nx, tt_nx, ct_nx, mct_nx, stopped_nx;
  logic        run_nx;

`ifndef TPG_MONITOR_STOP_EN
  logic unused_monitor;
  assign unused_monitor = MSTP | MSTRT;
`endif

  // Next-state logic; precedence GOJAM > MSTRT > MSTP (reset is in the register block).
  always_comb begin
    mode_nx = RUN;
    ph_nx   = ph;
    tc_nx   = tc;
    if (GOJAM) begin
      ph_nx = 2'd0;
      tc_nx = 4'd1;
    end else if (mode == HOLD) begin
      ph_nx = 2'd0;
      tc_nx = 4'd1;
`ifdef TPG_MONITOR_STOP_EN
      mode_nx = MSTRT ? RUN : HOLD;
`endif
    end else if (tc == 4'd0 || tc > 4'd12) begin
      ph_nx = 2'd0;
      tc_nx = 4'd1;
    end else if (ph == 2'd3) begin
      ph_nx = 2'd0;
      if (tc == 4'd12) begin
        tc_nx = 4'd1;
`ifdef TPG_MONITOR_STOP_EN
        if (MSTP) mode_nx = HOLD;
`endif
      end else begin
        tc_nx = tc + 4'd1;
      end
    end else begin
      ph_nx = ph + 2'd1;
    end
  end

  // Output decode of the next state, so the registered outputs line up with the state registers.
  always_comb begin
    run_nx = (mode_nx == RUN);
    t_nx   = '1;
    for (int unsigned k = 0; k < 12; k++) begin
      t_nx[k] = ~(run_nx && (tc_nx == 4'(k + 1)));
    end
    rt_nx  = ~(run_nx && ph_nx == 2'd0);
    wt_nx  = ~(run_nx && (ph_nx == 2'd1 || ph_nx == 2'd2));
    tt_nx  = ~(run_nx && ph_nx == 2'd2);
    ct_nx  = ~(run_nx && ph_nx == 2'd3);
    mct_nx = run_nx && tc_nx == 4'd12 && ph_nx == 2'd3;
`ifdef TPG_MONITOR_STOP_EN
    stopped_nx = ~run_nx;
`else
    stopped_nx = 1'b0;
`endif
  end

  // State and output registers with synchronous reset to RUN, T01, PH0.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      mode    <= RUN;
      ph      <= 2'd0;
      tc      <= 4'd1;
      T_n     <= 12'hFFE;
      RT_n    <= 1'b0;
      WT_n    <= 1'b1;
      TT_n    <= 1'b1;
      CT_n    <= 1'b1;
      MCT     <= 1'b0;
      STOPPED <= 1'b0;
    end else begin
      mode    <= mode_nx;
      ph      <= ph_nx;
      tc      <= tc_nx;
      T_n     <= t_nx;
      RT_n    <= rt_nx;
      WT_n    <= wt_nx;
      TT_n    <= tt_nx;
      CT_n    <= ct_nx;
      MCT     <= mct_nx;
      STOPPED <= stopped_nx;
    end
  end

  assign T10_n = T_n[9];

endmodule

// File: doc/time_pulse_gen.md
TIME_PULSE_GEN -- requirements
Module: time_pulse_gen

Interface
REQ-001 The block SHALL have the port SIM_CLK, input, 1 bit: the single simulation clock; every register updates on its rising edge.
REQ-002 The block SHALL have the port SIM_RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port GOJAM, input, 1 bit: restart request, active-high, sampled each clock.
REQ-004 The block SHALL have the port MSTP, input, 1 bit: monitor stop request, active-high level.
REQ-005 The block SHALL have the port MSTRT, input, 1 bit: monitor start/step request, active-high, sampled each clock.
REQ-006 The block SHALL have the port T_n, output, 12 bits: time pulses T01..T12, active-low one-hot; bit k-1 corresponds to Tk.
REQ-007 The block SHALL have the port T10_n, output, 1 bit: a copy of T_n bit 9.
REQ-008 The block SHALL have the port RT_n, output, 1 bit: read strobe, active-low.
REQ-009 The block SHALL have the port WT_n, output, 1 bit: write strobe, active-low.
REQ-010 The block SHALL have the port TT_n, output, 1 bit: transfer strobe, active-low.
REQ-011 The block SHALL have the port CT_n, output, 1 bit: clear strobe, active-low.
REQ-012 The block SHALL have the port MCT, output, 1 bit: end-of-memory-cycle pulse, active-high.
REQ-013 The block SHALL have the port STOPPED, output, 1 bit: high while in HOLD.

Function
REQ-014 State SHALL consist of: a 2-bit phase counter PH (0..3), a 4-bit time counter TC (1..12), and a 1-bit mode (RUN or HOLD).
REQ-015 All outputs SHALL be pure decodes of registered state, with no combinational path from any input.
REQ-016 In RUN, PH SHALL increment every clock; when PH=3, PH SHALL wrap to 0 and TC SHALL advance by one, with 12 wrapping to 1; one memory cycle is therefore 48 clocks.
REQ-017 In RUN, the outputs SHALL decode as follows: T_n bit TC-1 low and all other bits high; RT_n low when PH=0; WT_n low when PH=1 or PH=2; TT_n low when PH=2; CT_n low when PH=3.
REQ-018 MCT SHALL be high for exactly one clock, when in RUN with TC=12 and PH=3.
REQ-019 The MSTP input SHALL be sampled only in RUN with TC=12 and PH=3: if MSTP=1, the next state SHALL be HOLD; otherwise the next state SHALL be RUN with TC=1 and PH=0.
REQ-020 In HOLD, T_n SHALL be all ones, all strobes SHALL be high, MCT SHALL be 0 and STOPPED SHALL be 1; PH and TC SHALL be held at 0 and 1 respectively.
REQ-021 In HOLD, MSTRT=1 SHALL cause the next state to be RUN with TC=1 and PH=0; exactly one memory cycle then runs, and HOLD is re-entered if MSTP is still 1 at the end of T12.
REQ-022 MSTRT SHALL be ignored while in RUN.
REQ-023 GOJAM=1 in any state SHALL cause the next state to be RUN with TC=1 and PH=0, and SHALL NOT generate an MCT pulse.
REQ-024 Precedence SHALL be SIM_RST > GOJAM > MSTRT > MSTP.
REQ-025 Unreachable encodings (TC=0 or TC>12) SHALL recover to TC=1 and PH=0 on the next clock.

Reset
REQ-026 While SIM_RST=1 at a clock edge, the next state SHALL be RUN with TC=1 and PH=0.
REQ-027 In the first cycle after reset, the outputs SHALL be: T_n=12'hFFE, RT_n=0, WT_n=1, TT_n=1, CT_n=1, MCT=0, STOPPED=0.
REQ-028 Asserting reset mid-cycle or during HOLD SHALL produce the same reset state.

Configuration
REQ-029 Macro TPG_MONITOR_STOP_EN SHALL control the monitor stop feature: when it is defined, MSTP and MSTRT SHALL behave as specified in REQ-019 to REQ-022.
REQ-030 When TPG_MONITOR_STOP_EN is undefined, MSTP and MSTRT SHALL be ignored, HOLD SHALL be unreachable, and STOPPED SHALL be tied to 0.

Verification
REQ-031 Reset, then 48 free-running clocks: T_n SHALL step through T01..T12 with four clocks per pulse, MCT SHALL be high only at clock 47, and clock 48 SHALL show T01 with RT_n=0.
REQ-032 In each T slot, the strobe order SHALL be RT_n, WT_n, WT_n together with TT_n, CT_n; no two T_n bits SHALL be low at the same time.
REQ-033 Hold MSTP=1 from T05: the block SHALL enter HOLD after T12 PH3, with STOPPED=1 and T_n=12'hFFF, and remain there for 100 clocks.
REQ-034 From HOLD with MSTP=1, pulse MSTRT for one clock: exactly 48 clocks of RUN with one MCT SHALL follow, then HOLD again.
REQ-035 Assert GOJAM during T07 PH2: the next cycle SHALL show T01 PH0 with no MCT; asserting GOJAM together with MSTRT in HOLD SHALL also give RUN at T01.
REQ-036 Assert SIM_RST during T09 PH1 and also during HOLD: both cases SHALL produce T_n=12'hFFE and RT_n=0 on the following cycle; with the macro undefined, MSTP=1 SHALL never produce STOPPED.
